// File: rtl/one_operand_unit.sv
`default_nettype none
// ============================================================================
//  Module   : one_operand_unit
//  Purpose  : Execute unit for NOT/INC/DEC/SETC/CLRC/OUT/IN with one registered
//             valid/ready output stage; owns the CCR {C,N,Z} and output port.
//  Revision : 1.0
// ============================================================================
module one_operand_unit #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] PORT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rds,
    input  logic [2:0]       rd_tag,
    input  logic [WIDTH-1:0] in_port,
    input  logic             ccr_load,
    input  logic [2:0]       ccr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_tag,
    output logic             out_wb,
    output logic [2:0]       ccr,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] c_op_nop  = 3'b000;
    localparam logic [2:0] c_op_not  = 3'b001;
    localparam logic [2:0] c_op_inc  = 3'b010;
    localparam logic [2:0] c_op_dec  = 3'b011;
    localparam logic [2:0] c_op_setc = 3'b100;
    localparam logic [2:0] c_op_clrc = 3'b101;
    localparam logic [2:0] c_op_out  = 3'b110;
    localparam logic [2:0] c_op_in   = 3'b111;

    localparam logic [WIDTH:0] c_one = {{WIDTH{1'b0}}, 1'b1};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [2:0]       r_out_tag;
    logic             r_out_wb;
    logic [2:0]       r_ccr;
    logic [WIDTH-1:0] r_out_port;

    logic             w_accept;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_result;
    logic             w_wb;
    logic             w_upd_nz;
    logic [2:0]       w_ccr_op;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Extra top bit of the sum/difference is the carry/borrow out of bit WIDTH-1
    assign w_sum  = {1'b0, rds} + c_one;
    assign w_diff = {1'b0, rds} - c_one;

    always_comb begin
        w_result = '0;
        w_wb     = 1'b0;
        w_upd_nz = 1'b0;
        w_ccr_op = r_ccr;
        case (op)
            c_op_not: begin
                w_result = ~rds;
                w_wb     = 1'b1;
                w_upd_nz = 1'b1;
            end
            c_op_inc: begin
                w_result    = w_sum[WIDTH-1:0];
                w_wb        = 1'b1;
                w_upd_nz    = 1'b1;
                w_ccr_op[2] = w_sum[WIDTH];
            end
            c_op_dec: begin
                w_result    = w_diff[WIDTH-1:0];
                w_wb        = 1'b1;
                w_upd_nz    = 1'b1;
                w_ccr_op[2] = w_diff[WIDTH];
            end
            c_op_setc: w_ccr_op[2] = 1'b1;
            c_op_clrc: w_ccr_op[2] = 1'b0;
            c_op_out:  w_result    = rds;
            c_op_in: begin
                w_result = in_port;
                w_wb     = 1'b1;
            end
            c_op_nop: w_result = '0;
            default:  w_result = '0;
        endcase
        if (w_upd_nz) begin
            w_ccr_op[1] = w_result[WIDTH-1];
            w_ccr_op[0] = (w_result == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_wb    <= 1'b0;
            r_out_port  <= PORT_RESET;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
                r_out_tag   <= rd_tag;
                r_out_wb    <= w_wb;
                if (op == c_op_out) begin
                    r_out_port <= rds;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Interrupt-return restore wins over any same-edge flag update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ccr <= 3'b000;
        end else if (ccr_load) begin
            r_ccr <= ccr_in;
        end else if (w_accept) begin
            r_ccr <= w_ccr_op;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_wb    = r_out_wb;
    assign ccr       = r_ccr;
    assign out_port  = r_out_port;

endmodule
`default_nettype wire

// File: tb/tb_one_operand_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_one_operand_unit
//  Purpose  : Self-checking bench driving a 16-bit and an 8-bit instance in
//             lockstep from shared stimulus, with a reference model and queue.
//  Revision : 1.0
// ============================================================================
module tb_one_operand_unit;

    localparam logic [15:0] c_pr16 = 16'h5A5A;
    localparam logic [7:0]  c_pr8  = 8'hC3;

    typedef struct {
        logic        iv;
        logic [2:0]  op;
        logic [15:0] rds;
        logic [2:0]  tag;
        logic [15:0] inp;
        logic        ordy;
        logic        cl;
        logic [2:0]  ci;
        logic        exp_ready;
        logic [2:0]  exp_ccr;
        logic [15:0] exp_port;
    } vec_t;

    typedef struct {
        logic [15:0] d16;
        logic [7:0]  d8;
        logic [2:0]  tag;
        logic        wb;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic [15:0] rds;
    logic [2:0]  rd_tag;
    logic [15:0] in_port;
    logic        ccr_load;
    logic [2:0]  ccr_in;
    logic        out_ready;

    logic        in_ready16, out_valid16, out_wb16;
    logic [15:0] out_data16, out_port16;
    logic [2:0]  out_tag16, ccr16;
    logic        in_ready8, out_valid8, out_wb8;
    logic [7:0]  out_data8, out_port8;
    logic [2:0]  out_tag8, ccr8;

    int total;
    int bad;

    logic        m_valid;
    logic [2:0]  m_ccr16, m_ccr8;
    logic [15:0] m_port16;
    logic [7:0]  m_port8;
    exp_t        q[$];

    one_operand_unit #(.WIDTH(16), .PORT_RESET(c_pr16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .op(op), .rds(rds), .rd_tag(rd_tag), .in_port(in_port),
        .ccr_load(ccr_load), .ccr_in(ccr_in), .out_valid(out_valid16),
        .out_ready(out_ready), .out_data(out_data16), .out_tag(out_tag16),
        .out_wb(out_wb16), .ccr(ccr16), .out_port(out_port16)
    );

    one_operand_unit #(.WIDTH(8), .PORT_RESET(c_pr8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .op(op), .rds(rds[7:0]), .rd_tag(rd_tag), .in_port(in_port[7:0]),
        .ccr_load(ccr_load), .ccr_in(ccr_in), .out_valid(out_valid8),
        .out_ready(out_ready), .out_data(out_data8), .out_tag(out_tag8),
        .out_wb(out_wb8), .ccr(ccr8), .out_port(out_port8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour for a w-bit unit, operands carried in 16-bit containers
    function automatic void model_op(input int w, input logic [2:0] o, input logic [15:0] a_in,
                                     input logic [15:0] p_in, input logic [2:0] cc,
                                     output logic [15:0] res, output logic wb,
                                     output logic [2:0] ncc);
        logic [15:0] mask;
        logic [15:0] a;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        a    = a_in & mask;
        res  = 16'h0;
        wb   = 1'b0;
        ncc  = cc;
        case (o)
            3'd1: begin res = ~a & mask;          wb = 1'b1; ncc = {cc[2],     res[w-1], res == 16'h0}; end
            3'd2: begin res = (a + 16'd1) & mask; wb = 1'b1; ncc = {a == mask, res[w-1], res == 16'h0}; end
            3'd3: begin res = (a - 16'd1) & mask; wb = 1'b1; ncc = {a == 16'h0, res[w-1], res == 16'h0}; end
            3'd4: ncc[2] = 1'b1;
            3'd5: ncc[2] = 1'b0;
            3'd6: res = a;
            3'd7: begin res = p_in & mask; wb = 1'b1; end
            default: res = 16'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 1'b0;
        m_ccr16  = 3'b000;
        m_ccr8   = 3'b000;
        m_port16 = c_pr16;
        m_port8  = c_pr8;
        q.delete();
    endtask

    task automatic apply(input vec_t v);
        in_valid  = v.iv;
        op        = v.op;
        rds       = v.rds;
        rd_tag    = v.tag;
        in_port   = v.inp;
        out_ready = v.ordy;
        ccr_load  = v.cl;
        ccr_in    = v.ci;
        #1;
    endtask

    task automatic check_now();
        logic er;
        er = !m_valid || out_ready;
        chk("in_ready16", {31'b0, in_ready16}, {31'b0, er});
        chk("in_ready8", {31'b0, in_ready8}, {31'b0, er});
        chk("out_valid16", {31'b0, out_valid16}, {31'b0, m_valid});
        chk("out_valid8", {31'b0, out_valid8}, {31'b0, m_valid});
        if (m_valid) begin
            if (q.size() == 0) begin
                chk("queue_nonempty", 32'd0, 32'd1);
            end else begin
                chk("out_data16", {16'b0, out_data16}, {16'b0, q[0].d16});
                chk("out_tag16", {29'b0, out_tag16}, {29'b0, q[0].tag});
                chk("out_wb16", {31'b0, out_wb16}, {31'b0, q[0].wb});
                chk("out_data8", {24'b0, out_data8}, {24'b0, q[0].d8});
                chk("out_tag8", {29'b0, out_tag8}, {29'b0, q[0].tag});
                chk("out_wb8", {31'b0, out_wb8}, {31'b0, q[0].wb});
            end
        end
        chk("ccr16", {29'b0, ccr16}, {29'b0, m_ccr16});
        chk("ccr8", {29'b0, ccr8}, {29'b0, m_ccr8});
        chk("out_port16", {16'b0, out_port16}, {16'b0, m_port16});
        chk("out_port8", {24'b0, out_port8}, {24'b0, m_port8});
    endtask

    task automatic advance();
        logic        acc;
        logic [15:0] r16, r8;
        logic        wb16, wb8;
        logic [2:0]  n16, n8;
        exp_t        e;
        acc = in_valid && (!m_valid || out_ready);
        model_op(16, op, rds, in_port, m_ccr16, r16, wb16, n16);
        model_op(8, op, rds, in_port, m_ccr8, r8, wb8, n8);
        if (m_valid && out_ready && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            e.d16 = r16;
            e.d8  = r8[7:0];
            e.tag = rd_tag;
            e.wb  = wb16;
            q.push_back(e);
            if (op == 3'd6) begin
                m_port16 = rds;
                m_port8  = rds[7:0];
            end
        end
        if (ccr_load) begin
            m_ccr16 = ccr_in;
            m_ccr8  = ccr_in;
        end else if (acc) begin
            m_ccr16 = n16;
            m_ccr8  = n8;
        end
        m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic iv, input logic [2:0] o, input logic [15:0] r,
                                input logic [2:0] t, input logic [15:0] p, input logic ordy,
                                input logic cl, input logic [2:0] ci, input logic er,
                                input logic [2:0] ec, input logic [15:0] ep);
        vec_t v;
        v.iv = iv; v.op = o; v.rds = r; v.tag = t; v.inp = p; v.ordy = ordy;
        v.cl = cl; v.ci = ci; v.exp_ready = er; v.exp_ccr = ec; v.exp_port = ep;
        return v;
    endfunction

    vec_t tbl[14];
    vec_t rv;

    initial begin
        total = 0;
        bad   = 0;
        //            iv  op    rds       tag   in_port   ordy cl  ci      rdy  ccr     port
        tbl[0]  = mk(1, 3'd2, 16'hFFFF, 3'd1, 16'h0000, 1, 0, 3'b000, 1, 3'b101, c_pr16);
        tbl[1]  = mk(1, 3'd3, 16'h0000, 3'd2, 16'h0000, 1, 0, 3'b000, 1, 3'b110, c_pr16);
        tbl[2]  = mk(1, 3'd1, 16'h00FF, 3'd3, 16'h0000, 1, 0, 3'b000, 1, 3'b110, c_pr16);
        tbl[3]  = mk(1, 3'd4, 16'h0000, 3'd0, 16'h0000, 1, 0, 3'b000, 1, 3'b110, c_pr16);
        tbl[4]  = mk(1, 3'd5, 16'h0000, 3'd0, 16'h0000, 1, 0, 3'b000, 1, 3'b010, c_pr16);
        tbl[5]  = mk(1, 3'd6, 16'h1234, 3'd7, 16'h0000, 1, 0, 3'b000, 1, 3'b010, 16'h1234);
        tbl[6]  = mk(1, 3'd7, 16'h0000, 3'd4, 16'h8000, 1, 0, 3'b000, 1, 3'b010, 16'h1234);
        tbl[7]  = mk(1, 3'd2, 16'h0005, 3'd5, 16'h1111, 0, 0, 3'b000, 0, 3'b010, 16'h1234);
        tbl[8]  = mk(1, 3'd2, 16'h0005, 3'd5, 16'h2222, 0, 0, 3'b000, 0, 3'b010, 16'h1234);
        tbl[9]  = mk(1, 3'd2, 16'h0005, 3'd5, 16'h3333, 0, 0, 3'b000, 0, 3'b010, 16'h1234);
        tbl[10] = mk(1, 3'd2, 16'h0005, 3'd5, 16'h0000, 1, 0, 3'b000, 1, 3'b000, 16'h1234);
        tbl[11] = mk(1, 3'd2, 16'h7FFF, 3'd6, 16'h0000, 1, 1, 3'b010, 1, 3'b010, 16'h1234);
        tbl[12] = mk(0, 3'd0, 16'h0000, 3'd0, 16'h0000, 1, 0, 3'b000, 1, 3'b010, 16'h1234);
        tbl[13] = mk(0, 3'd0, 16'h0000, 3'd0, 16'h0000, 1, 0, 3'b000, 1, 3'b010, 16'h1234);

        rst_n = 1'b0;
        apply(mk(0, 3'd0, 16'h0, 3'd0, 16'h0, 1, 0, 3'b000, 1, 3'b000, c_pr16));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_data16", {16'b0, out_data16}, 32'h0);
        chk("reset_out_tag16", {29'b0, out_tag16}, 32'h0);
        chk("reset_out_wb16", {31'b0, out_wb16}, 32'h0);
        check_now();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
            chk($sformatf("vec%0d_ready", i), {31'b0, in_ready16}, {31'b0, tbl[i].exp_ready});
            check_now();
            advance();
            chk($sformatf("vec%0d_ccr", i), {29'b0, ccr16}, {29'b0, tbl[i].exp_ccr});
            chk($sformatf("vec%0d_port", i), {16'b0, out_port16}, {16'b0, tbl[i].exp_port});
        end

        // Pending result plus a loaded CCR and port, then an async reset mid-cycle
        apply(mk(1, 3'd6, 16'hABCD, 3'd3, 16'h0, 0, 1, 3'b111, 1, 3'b111, 16'hABCD));
        check_now();
        advance();
        apply(mk(0, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 3'b000, 0, 3'b111, 16'hABCD));
        check_now();
        chk("pre_reset_ccr", {29'b0, ccr16}, 32'h7);
        chk("pre_reset_port", {16'b0, out_port16}, 32'hABCD);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid16", {31'b0, out_valid16}, 32'h0);
        chk("async_valid8", {31'b0, out_valid8}, 32'h0);
        chk("async_ccr16", {29'b0, ccr16}, 32'h0);
        chk("async_ccr8", {29'b0, ccr8}, 32'h0);
        chk("async_port16", {16'b0, out_port16}, {16'b0, c_pr16});
        chk("async_port8", {24'b0, out_port8}, {24'b0, c_pr8});
        chk("async_ready16", {31'b0, in_ready16}, 32'h1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_now();
        @(posedge clk);
        #1;

        for (int i = 0; i < 80; i++) begin
            rv.iv   = ($urandom_range(0, 3) != 0);
            rv.op   = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       rv.rds = 16'hFFFF;
                1:       rv.rds = 16'h0000;
                2:       rv.rds = 16'h00FF;
                default: rv.rds = 16'($urandom);
            endcase
            rv.tag  = 3'($urandom_range(0, 7));
            rv.inp  = 16'($urandom);
            rv.ordy = ($urandom_range(0, 3) != 0);
            rv.cl   = ($urandom_range(0, 9) == 0);
            rv.ci   = 3'($urandom_range(0, 7));
            apply(rv);
            check_now();
            advance();
        end
        apply(mk(0, 3'd0, 16'h0, 3'd0, 16'h0, 1, 0, 3'b000, 1, 3'b000, 16'h0));
        check_now();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/one_operand_unit.md
# one_operand_unit

- Parametrised, pipelined execute unit for the processor's one-operand instruction group: NOT, INC, DEC, SETC, CLRC, OUT, IN.
- Register width is configurable. Results leave through one registered output stage with a valid/ready handshake.
- The unit owns the architectural condition-code register (Z, N, C) and the output-port register.
- It sits in the execute stage, between decode/register-read and the write-back mux.

## Interface
Parameters:
- WIDTH, 16, datapath and port width in bits (minimum 2).
- PORT_RESET, 0, reset value of the output-port register.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- op  in  3  opcode: 000 NOP, 001 NOT, 010 INC, 011 DEC, 100 SETC, 101 CLRC, 110 OUT, 111 IN.
- rds  in  WIDTH  source/destination operand.
- rd_tag  in  3  destination register index, carried to the result.
- in_port  in  WIDTH  external input port.
- ccr_load  in  1  load the CCR from ccr_in (interrupt return).
- ccr_in  in  3  CCR restore value, {C,N,Z}.
- out_valid  out  1  result valid.
- out_ready  in  1  write-back consumes the result.
- out_data  out  WIDTH  result value.
- out_tag  out  3  destination index of the result.
- out_wb  out  1  result must be written to the register file.
- ccr  out  3  condition codes {C,N,Z}, registered.
- out_port  out  WIDTH  output-port register.

## Operation
Accept:
- A request is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready (single output stage, full throughput).

Result per opcode (all arithmetic is modulo 2^WIDTH):
- NOT: ~rds.
- INC: rds+1.
- DEC: rds-1.
- OUT: rds, and the out_port register loads rds.
- IN: in_port, sampled at the accept edge.
- NOP, SETC, CLRC: out_data = 0.

Write-back flag:
- out_wb = 1 for NOT, INC, DEC, IN.
- out_wb = 0 for NOP, SETC, CLRC, OUT.

Flag updates, applied at the accept edge:
- NOT: Z = (result == 0); N = result[WIDTH-1]; C unchanged.
- INC: Z and N as for NOT; C = carry out of bit WIDTH-1 (set only when rds is all ones).
- DEC: Z and N as for NOT; C = borrow (set only when rds == 0).
- SETC: C = 1; Z and N unchanged.
- CLRC: C = 0; Z and N unchanged.
- OUT, IN, NOP: no flag change.

Simultaneous events:
- ccr_load asserted at an edge overrides any flag update from an op accepted at the same edge. The op's data result is still produced.
- ccr_load is independent of the handshake and takes effect even when no request is accepted.

Stalls:
- While out_valid && !out_ready, out_data, out_tag and out_wb hold stable. in_ready is 0 and no CCR or port update occurs from new requests.

## Timing
Reset (rst_n low, asynchronous):
- out_valid = 0, out_data = 0, out_tag = 0, out_wb = 0, ccr = 3'b000, out_port = PORT_RESET.
- in_ready = 1 once out_valid is 0.

Latency and throughput:
- Latency is 1 cycle: a request accepted at edge k gives out_valid = 1 and its result after edge k.
- ccr and out_port reflect the op after edge k.
- Back-to-back accepts are allowed every cycle while out_ready = 1.

Output valid handling:
- out_valid clears at an edge where out_ready = 1 and no new accept occurs.
- out_valid stays 1 when a new accept replaces the consumed result.

Reset mid-operation:
- Any pending result is discarded. CCR and port values return to their reset values. No partial update persists.

Wrap-around:
- INC of all-ones gives 0 with Z = 1, C = 1.
- DEC of 0 gives all-ones with N = 1, C = 1.

## Test plan
- Reset, then INC rds=16'hFFFF with out_ready=1 -> next cycle out_data=16'h0000, out_wb=1, ccr=3'b101 (C=1, Z=1).
- DEC rds=16'h0000, then NOT rds=16'h00FF back-to-back -> results 16'hFFFF with ccr=3'b110, then 16'hFF00 with ccr=3'b110 (C retained from DEC, N=1).
- SETC, CLRC, then OUT rds=16'h1234 -> C goes 1 then 0; Z and N unchanged; out_wb=0 for all three; out_port=16'h1234 after the OUT edge.
- IN with in_port=16'h8000 while out_ready=0 for 3 cycles -> out_data holds 16'h8000 and in_ready=0 throughout; a second request is accepted only on the edge where out_ready=1.
- INC accepted on the same edge as ccr_load=1 with ccr_in=3'b010 -> ccr=3'b010, out_data=rds+1.
- rst_n pulsed low while out_valid=1, ccr=3'b111, out_port=16'hABCD -> immediately out_valid=0, ccr=0, out_port=PORT_RESET. Repeat the directed cases with WIDTH=8.
